decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have `clk` (input, 1): single clock; all state updates on the rising edge.
REQ-002 SHALL have `rst_n` (input, 1): asynchronous, active-low reset.
REQ-003 SHALL have `in_valid` (input, 1): `in_instr` holds a valid instruction.
REQ-004 SHALL have `in_ready` (output, 1): the stage accepts an instruction this cycle.
REQ-005 SHALL have `in_instr` (input, 32): RV32I instruction word.
REQ-006 SHALL have `wb_we` (input, 1): writeback enable.
REQ-007 SHALL have `wb_rd` (input, 5): writeback destination register.
REQ-008 SHALL have `wb_data` (input, 32): writeback value.
REQ-009 SHALL have `out_valid` (output, 1): the output bundle is valid.
REQ-010 SHALL have `out_ready` (input, 1): the ALU stage consumes the bundle.
REQ-011 SHALL have `out_alu_op` (output, 4): ALU opcode, {bit30, funct3} encoding (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111).
REQ-012 SHALL have `out_in1` (output, 32): ALU operand 1.
REQ-013 SHALL have `out_in2` (output, 32): ALU operand 2.
REQ-014 SHALL have `out_rd` (output, 5): destination register.
REQ-015 SHALL have `out_rd_we` (output, 1): the result is to be written back.
REQ-016 SHALL have `out_illegal` (output, 1): the instruction is unsupported or malformed.

Function
REQ-017 SHALL contain a 32x32 register file; x0 reads 0 and ignores writes.
REQ-018 SHALL write `wb_data` to `wb_rd` at the clock edge when `wb_we`=1 and `wb_rd`!=0.
REQ-019 SHALL drive `in_ready` = !`out_valid` || `out_ready` (combinational).
REQ-020 SHALL accept an instruction when `in_valid` && `in_ready`; rs1, rs2 and decode are sampled in that cycle, and the output registers load at that edge (latency 1 cycle).
REQ-021 SHALL set `out_valid` on accept and clear it on `out_ready` without a new accept; while `out_valid`=1 && `out_ready`=0, all out_* SHALL hold stable.
REQ-022 SHALL support back-to-back accept and consume in the same cycle, giving full throughput of 1 instruction per cycle.
REQ-023 SHALL decode OP (0110011) as: alu_op = {funct7[5], funct3}, in1 = rs1, in2 = rs2, rd_we = 1.
- Legal only if funct7 = 0000000, or funct7 = 0100000 with funct3 000 or 101.
REQ-024 SHALL decode OP-IMM (0010011) as: in1 = rs1, in2 = sign-extended imm[11:0], rd_we = 1.
- alu_op = {0, funct3}, except funct3 = 101 uses {instr[30], 101}.
- Slli/srli/srai: funct7 must be 0000000 (or 0100000 for funct3 = 101), otherwise illegal.
REQ-025 SHALL decode LUI (0110111) as: alu_op = ADD, in1 = 0, in2 = {instr[31:12], 12'h000}, rd_we = 1.
REQ-026 SHALL treat any other opcode or illegal encoding as follows: out_illegal = 1, alu_op = ADD, in1 = in2 = 0, rd_we = 0; `out_rd` = instr[11:7] still.
REQ-027 SHALL force rd_we = 0 when rd = 0, with no illegal flag.
REQ-028 SHALL NOT detect data hazards; back-to-back dependency handling is the writeback path's responsibility.

Reset
REQ-029 SHALL, while `rst_n` = 0, clear `out_valid`, `out_alu_op`, `out_in1`, `out_in2`, `out_rd`, `out_rd_we` and `out_illegal` to 0, and clear all registers x1..x31 to 0.
REQ-030 SHALL, on reset asserted mid-transfer, discard the pending bundle; the first accept is possible in the first cycle after deassertion.

Configuration
REQ-031 SHALL, when `REGFILE_BYPASS_EN` is defined, substitute `wb_data` for a read of rs1/rs2 equal to `wb_rd` when `wb_we` = 1 and `wb_rd` != 0 in the accept cycle.
REQ-032 SHALL, when `REGFILE_BYPASS_EN` is undefined, return the pre-write register value in that case.

Verification
REQ-033 Reset, then write x1=5 and x2=7, then issue `add x3,x1,x2` (0x002081B3) -> next cycle out_valid=1, alu_op=0000, in1=5, in2=7, rd=3, rd_we=1.
REQ-034 `srai x4,x1,3` with x1=0x80000000 -> alu_op=1101, in2=3; `addi x5,x0,-1` -> in1=0, in2=0xFFFFFFFF.
REQ-035 `lui x6,0x12345` -> alu_op=0000, in1=0, in2=0x12345000, rd=6.
REQ-036 Instruction 0x0000007F, or OP with funct7=0000001 -> out_illegal=1, rd_we=0, in1=in2=0.
REQ-037 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; then out_ready=1 -> one consume and one accept in the same cycle.
REQ-038 wb_we=1, wb_rd=1, wb_data=0xA5 in the same cycle as accepting `add x3,x1,x0` (old x1=5) -> in1=0xA5 with `REGFILE_BYPASS_EN`, 5 without it; wb_rd=0 writes are ignored.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: 32x32 register file, OP/OP-IMM/LUI decode, valid/ready output register.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback into the operand read.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [31:0] out_in1,
    output logic [31:0] out_in2,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [31:0] rf [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        accept;

    logic [3:0]  d_alu_op;
    logic [31:0] d_in1;
    logic [31:0] d_in2;
    logic        d_rd_we;
    logic        d_illegal;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_val = wb_data;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_val = wb_data;
`endif
    end

    always_comb begin
        d_alu_op  = 4'b0000;
        d_in1     = 32'd0;
        d_in2     = 32'd0;
        d_rd_we   = 1'b0;
        d_illegal = 1'b1;
        case (opcode)
            OPC_OP: begin
                if ((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
                    d_illegal = 1'b0;
                    d_alu_op  = {funct7[5], funct3};
                    d_in1     = rs1_val;
                    d_in2     = rs2_val;
                    d_rd_we   = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Shifts pass only the shamt field so the funct7 bits never reach the ALU.
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) begin
                        d_illegal = 1'b0;
                        d_alu_op  = 4'b0001;
                        d_in1     = rs1_val;
                        d_in2     = {27'd0, in_instr[24:20]};
                        d_rd_we   = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) begin
                        d_illegal = 1'b0;
                        d_alu_op  = {in_instr[30], 3'b101};
                        d_in1     = rs1_val;
                        d_in2     = {27'd0, in_instr[24:20]};
                        d_rd_we   = 1'b1;
                    end
                end else begin
                    d_illegal = 1'b0;
                    d_alu_op  = {1'b0, funct3};
                    d_in1     = rs1_val;
                    d_in2     = {{20{in_instr[31]}}, in_instr[31:20]};
                    d_rd_we   = 1'b1;
                end
            end
            OPC_LUI: begin
                d_illegal = 1'b0;
                d_in2     = {in_instr[31:12], 12'h000};
                d_rd_we   = 1'b1;
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
        if (rd == 5'd0) d_rd_we = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_alu_op  <= 4'd0;
            out_in1     <= 32'd0;
            out_in2     <= 32'd0;
            out_rd      <= 5'd0;
            out_rd_we   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_alu_op  <= d_alu_op;
            out_in1     <= d_in1;
            out_in2     <= d_in2;
            out_rd      <= rd;
            out_rd_we   <= d_rd_we;
            out_illegal <= d_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h000000A5;
`else
    localparam logic [31:0] BYP_EXP = 32'h00000005;
`endif

    // {valid, alu_op, in1, in2, rd, rd_we, illegal}
    wire [75:0] bundle = {out_valid, out_alu_op, out_in1, out_in2, out_rd, out_rd_we, out_illegal};

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_in1(out_in1), .out_in2(out_in2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        wb_we = 1'b1; wb_rd = r; wb_data = v;
        step();
        wb_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr);
        in_valid = 1'b1; in_instr = instr;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; wb_we = 1'b0; wb_rd = 5'd0;
        wb_data = 32'd0; out_ready = 1'b1;
        #2;
        n_cmp++;
        if (bundle !== 76'd0) begin
            n_err++; $display("FAIL reset_bundle: got %h expected %h", bundle, 76'd0);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_op();
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd7);
        issue(32'h002081B3);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL op_add: got %h expected %h", bundle, {1'b1, 4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
        end
        issue(32'h402081B3);
        n_cmp++;
        if (bundle !== {1'b1, 4'h8, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL op_sub: got %h expected %h", bundle, {1'b1, 4'h8, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
        end
        issue(32'h022081B3);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL op_funct7_illegal: got %h expected %h", bundle, {1'b1, 4'h0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1});
        end
        issue(32'h00208033);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL op_rd0: got %h expected %h", bundle, {1'b1, 4'h0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0});
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL op_consume: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_op_imm();
        write_reg(5'd1, 32'h80000000);
        issue(32'h4030D213);
        n_cmp++;
        if (bundle !== {1'b1, 4'hD, 32'h80000000, 32'd3, 5'd4, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL imm_srai: got %h expected %h", bundle, {1'b1, 4'hD, 32'h80000000, 32'd3, 5'd4, 1'b1, 1'b0});
        end
        issue(32'hFFF00293);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL imm_addi_neg: got %h expected %h", bundle, {1'b1, 4'h0, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0});
        end
        issue(32'h40309213);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd0, 32'd0, 5'd4, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL imm_slli_illegal: got %h expected %h", bundle, {1'b1, 4'h0, 32'd0, 32'd0, 5'd4, 1'b0, 1'b1});
        end
    endtask

    task automatic test_lui_illegal();
        issue(32'h12345337);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd0, 32'h12345000, 5'd6, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL lui: got %h expected %h", bundle, {1'b1, 4'h0, 32'd0, 32'h12345000, 5'd6, 1'b1, 1'b0});
        end
        issue(32'h0000007F);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL bad_opcode: got %h expected %h", bundle, {1'b1, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h12345337;
        step();
        in_instr = 32'hFFF00293;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({in_ready, bundle} !== {1'b0, 1'b1, 4'h0, 32'd0, 32'h12345000, 5'd6, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, {in_ready, bundle},
                                  {1'b0, 1'b1, 4'h0, 32'd0, 32'h12345000, 5'd6, 1'b1, 1'b0});
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL swap_bundle: got %h expected %h", bundle, {1'b1, 4'h0, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0});
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_bypass();
        write_reg(5'd1, 32'd5);
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hA5;
        issue(32'h000081B3);
        wb_we = 1'b0;
        n_cmp++;
        if (out_in1 !== BYP_EXP) begin
            n_err++; $display("FAIL bypass_in1: got %h expected %h", out_in1, BYP_EXP);
        end
        issue(32'h000081B3);
        n_cmp++;
        if (out_in1 !== 32'hA5) begin
            n_err++; $display("FAIL after_write_in1: got %h expected %h", out_in1, 32'hA5);
        end
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h77;
        issue(32'h000001B3);
        wb_we = 1'b0;
        issue(32'h000001B3);
        n_cmp++;
        if ({out_in1, out_in2} !== 64'd0) begin
            n_err++; $display("FAIL x0_write_ignored: got %h expected 0", {out_in1, out_in2});
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue(32'h002081B3);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bundle !== 76'd0) begin
            n_err++; $display("FAIL mid_reset_bundle: got %h expected 0", bundle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(32'h002081B3);
        n_cmp++;
        if (bundle !== {1'b1, 4'h0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL post_reset_accept: got %h expected %h", bundle, {1'b1, 4'h0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_op();
        test_op_imm();
        test_lui_illegal();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
